// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM states,
// instruction word width and default memory geometry.
package program_loader_pkg;

    localparam int INSTR_W             = 32;
    localparam int DEFAULT_ADDR_W      = 7;
    localparam int DEFAULT_DEPTH       = 128;
    localparam int DEFAULT_HOLD_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_HOLD  = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Packs four accepted bytes (MSB first) into a 32-bit word. Used for both
// program words and the trailing checksum word.
module byte_assembler
    import program_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               accept,
    input  logic [7:0]         byte_in,
    output logic               completing,
    output logic [INSTR_W-1:0] word_next,
    output logic               word_valid,
    output logic [INSTR_W-1:0] word
);

    logic [1:0] byte_cnt;

    // completing/word_next let the loader register its write in the same
    // edge that accepts the fourth byte, one cycle ahead of word_valid.
    assign word_next  = {word[INSTR_W-9:0], byte_in};
    assign completing = accept && (byte_cnt == 2'd3);

    // clear wins over accept so a word finishing on the clearing edge
    // never raises a stale word_valid in the following state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt   <= 2'd0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                byte_cnt <= 2'd0;
                word     <= '0;
            end else if (accept) begin
                word       <= word_next;
                byte_cnt   <= byte_cnt + 2'd1;
                word_valid <= (byte_cnt == 2'd3);
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a byte-streamed program into instruction memory, verifies a trailing
// XOR checksum and releases the computer from reset only after a good load.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         word_count,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               wr_instr_en,
    output logic [ADDR_W-1:0]  wr_instr_addr,
    output logic [INSTR_W-1:0] wr_instr,
    output logic               comp_rst,
    output logic               comp_en,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t              state;
    logic [7:0]          count_lat;
    logic [ADDR_W-1:0]   word_idx;
    logic [INSTR_W-1:0]  checksum;
    logic [HOLD_W-1:0]   hold_cnt;

    logic                accept;
    logic                count_ok;
    logic                start_ok;
    logic                last_word;
    logic                enter_check;
    logic                asm_clear;
    logic                asm_completing;
    logic                asm_word_valid;
    logic [INSTR_W-1:0]  asm_word_next;
    logic [INSTR_W-1:0]  asm_word;

    assign accept      = byte_valid && byte_ready;
    assign count_ok    = (word_count != 8'd0) && (int'(word_count) <= DEPTH);
    assign start_ok    = start && count_ok &&
                         (state == ST_IDLE || state == ST_RUN || state == ST_ERR);
    assign last_word   = (int'(word_idx) == int'(count_lat) - 1);
    assign enter_check = (state == ST_LOAD) && asm_completing && last_word;
    assign asm_clear   = start_ok || enter_check;

    byte_assembler u_byte_assembler (
        .clk        (clk),
        .rst        (rst),
        .clear      (asm_clear),
        .accept     (accept),
        .byte_in    (byte_in),
        .completing (asm_completing),
        .word_next  (asm_word_next),
        .word_valid (asm_word_valid),
        .word       (asm_word)
    );

    // Every output is updated on the transition into the state that owns it,
    // so all of them come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            count_lat     <= 8'd0;
            word_idx      <= '0;
            checksum      <= '0;
            hold_cnt      <= '0;
            byte_ready    <= 1'b0;
            wr_instr_en   <= 1'b0;
            wr_instr_addr <= '0;
            wr_instr      <= '0;
            comp_rst      <= 1'b0;
            comp_en       <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            wr_instr_en <= 1'b0;
            case (state)
                ST_IDLE, ST_RUN, ST_ERR: begin
                    if (start) begin
                        count_lat  <= word_count;
                        comp_rst   <= 1'b0;
                        comp_en    <= 1'b1;
                        done       <= 1'b0;
                        if (count_ok) begin
                            state      <= ST_LOAD;
                            word_idx   <= '0;
                            checksum   <= '0;
                            byte_ready <= 1'b1;
                            busy       <= 1'b1;
                            error      <= 1'b0;
                        end else begin
                            state      <= ST_ERR;
                            byte_ready <= 1'b0;
                            busy       <= 1'b0;
                            error      <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    if (asm_completing) begin
                        wr_instr_en   <= 1'b1;
                        wr_instr_addr <= word_idx;
                        wr_instr      <= asm_word_next;
                        checksum      <= checksum ^ asm_word_next;
                        word_idx      <= word_idx + ADDR_W'(1);
                        if (last_word) begin
                            state <= ST_CHECK;
                        end
                    end
                end

                ST_CHECK: begin
                    if (asm_word_valid) begin
                        byte_ready <= 1'b0;
                        if (asm_word == checksum) begin
                            state    <= ST_HOLD;
                            hold_cnt <= '0;
                        end else begin
                            state <= ST_ERR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end
                    end
                end

                ST_HOLD: begin
                    if (int'(hold_cnt) == HOLD_CYCLES - 1) begin
                        state    <= ST_RUN;
                        comp_rst <= 1'b1;
                        comp_en  <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus randomized
// loads compared against a queue-based model of the expected writes.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  word_count;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_instr_en;
    logic [6:0]  wr_instr_addr;
    logic [31:0] wr_instr;
    logic        comp_rst;
    logic        comp_en;
    logic        busy;
    logic        done;
    logic        error;

    int checks   = 0;
    int failures = 0;
    int ready_lows;

    logic [31:0] prog_q[$];
    logic [6:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    program_loader dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .word_count    (word_count),
        .byte_in       (byte_in),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .wr_instr_en   (wr_instr_en),
        .wr_instr_addr (wr_instr_addr),
        .wr_instr      (wr_instr),
        .comp_rst      (comp_rst),
        .comp_en       (comp_en),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_instr_en) begin
            wr_addr_q.push_back(wr_instr_addr);
            wr_data_q.push_back(wr_instr);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] model_xor();
        logic [31:0] x = 32'h0;
        foreach (prog_q[i]) x ^= prog_q[i];
        return x;
    endfunction

    task automatic pulse_start(input logic [7:0] cnt);
        word_count = cnt;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got = 1'b0;
        byte_in    = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (byte_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("[TB] FAIL handshake: byte 0x%02h not accepted, byte_ready=%0b expected 1", b, byte_ready);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 3; k >= 0; k--) begin
            repeat (gap) begin
                @(posedge clk);
                #1;
                if (byte_ready !== 1'b1) ready_lows++;
            end
            send_byte(w[8*k +: 8]);
        end
    endtask

    task automatic send_stream(input logic [31:0] csum, input int gap);
        ready_lows = 0;
        foreach (prog_q[i]) send_word(prog_q[i], gap);
        send_word(csum, gap);
    endtask

    task automatic wait_outcome();
        for (int i = 0; i < 60; i++) begin
            if (done || error) return;
            @(posedge clk);
            #1;
        end
        checks++;
        failures++;
        $display("[TB] FAIL outcome_timeout: done=%0b error=%0b, expected one of them high", done, error);
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++; if (comp_rst !== 1'b0) begin failures++; $display("[TB] FAIL reset_comp_rst: got %0b expected 0", comp_rst); end
        checks++; if (comp_en !== 1'b1) begin failures++; $display("[TB] FAIL reset_comp_en: got %0b expected 1", comp_en); end
        checks++; if (wr_instr_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_en: got %0b expected 0", wr_instr_en); end
        checks++; if (wr_instr_addr !== 7'd0) begin failures++; $display("[TB] FAIL reset_wr_addr: got %0d expected 0", wr_instr_addr); end
        checks++; if (wr_instr !== 32'h0) begin failures++; $display("[TB] FAIL reset_wr_data: got %08h expected 0", wr_instr); end
        checks++; if (byte_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_byte_ready: got %0b expected 0", byte_ready); end
        checks++; if ({busy, done, error} !== 3'b000) begin failures++; $display("[TB] FAIL reset_status: got busy/done/error=%03b expected 000", {busy, done, error}); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (byte_ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_quiet: got ready=%0b busy=%0b expected 0 0", byte_ready, busy); end
    endtask

    task automatic test_good_load();
        int hold_bad = 0;
        clear_log();
        prog_q = '{32'h20010005, 32'h20020003};
        pulse_start(8'd2);
        send_stream(32'h00030006, 0);
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL good_check_cycle: got done=%0b busy=%0b expected 0 1", done, busy); end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (comp_rst !== 1'b0 || done !== 1'b0) hold_bad++;
        end
        checks++; if (hold_bad != 0) begin failures++; $display("[TB] FAIL good_hold: %0d of 4 hold cycles released early, expected 0", hold_bad); end
        @(posedge clk);
        #1;
        checks++; if ({comp_rst, comp_en, done, busy} !== 4'b1010) begin failures++; $display("[TB] FAIL good_run: got comp_rst/comp_en/done/busy=%04b expected 1010", {comp_rst, comp_en, done, busy}); end
        checks++; if (wr_addr_q.size() != 2) begin failures++; $display("[TB] FAIL good_strobes: got %0d writes expected 2", wr_addr_q.size()); end
        for (int i = 0; i < wr_addr_q.size() && i < prog_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== 7'(i) || wr_data_q[i] !== prog_q[i]) begin
                failures++;
                $display("[TB] FAIL good_write%0d: got addr=%0d data=%08h expected addr=%0d data=%08h", i, wr_addr_q[i], wr_data_q[i], i, prog_q[i]);
            end
        end
    endtask

    task automatic test_bad_checksum();
        clear_log();
        prog_q = '{32'h20010005, 32'h20020003};
        pulse_start(8'd2);
        send_stream(32'h00000000, 0);
        wait_outcome();
        checks++; if ({error, done, comp_rst, comp_en} !== 4'b1001) begin failures++; $display("[TB] FAIL bad_csum_err: got error/done/comp_rst/comp_en=%04b expected 1001", {error, done, comp_rst, comp_en}); end
        repeat (6) @(posedge clk);
        #1;
        checks++; if ({error, comp_rst, comp_en, byte_ready} !== 4'b1010) begin failures++; $display("[TB] FAIL bad_csum_held: got error/comp_rst/comp_en/ready=%04b expected 1010", {error, comp_rst, comp_en, byte_ready}); end
        pulse_start(8'd2);
        send_stream(model_xor(), 0);
        wait_outcome();
        checks++; if (done !== 1'b1 || error !== 1'b0) begin failures++; $display("[TB] FAIL bad_csum_recover: got done=%0b error=%0b expected 1 0", done, error); end
    endtask

    task automatic test_stalled_stream();
        clear_log();
        prog_q = '{32'h20010005, 32'h20020003};
        pulse_start(8'd2);
        send_stream(32'h00030006, 3);
        checks++; if (ready_lows != 0) begin failures++; $display("[TB] FAIL stall_ready: byte_ready low in %0d stall cycles, expected 0", ready_lows); end
        wait_outcome();
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL stall_done: got %0b expected 1", done); end
        checks++; if (wr_addr_q.size() != 2) begin failures++; $display("[TB] FAIL stall_strobes: got %0d writes expected 2", wr_addr_q.size()); end
        for (int i = 0; i < wr_addr_q.size() && i < prog_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== 7'(i) || wr_data_q[i] !== prog_q[i]) begin
                failures++;
                $display("[TB] FAIL stall_write%0d: got addr=%0d data=%08h expected addr=%0d data=%08h", i, wr_addr_q[i], wr_data_q[i], i, prog_q[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        clear_log();
        pulse_start(8'd2);
        send_word(32'h20010005, 0);
        send_byte(8'h20);
        send_byte(8'h02);
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({byte_ready, busy, done, error, wr_instr_en} !== 5'b00000) begin failures++; $display("[TB] FAIL async_status: got ready/busy/done/error/wr_en=%05b expected 00000", {byte_ready, busy, done, error, wr_instr_en}); end
        checks++; if (wr_instr !== 32'h0 || wr_instr_addr !== 7'd0) begin failures++; $display("[TB] FAIL async_wr: got addr=%0d data=%08h expected 0 00000000", wr_instr_addr, wr_instr); end
        checks++; if (comp_rst !== 1'b0 || comp_en !== 1'b1) begin failures++; $display("[TB] FAIL async_comp: got comp_rst=%0b comp_en=%0b expected 0 1", comp_rst, comp_en); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log();
        prog_q = '{32'hDEADBEEF};
        pulse_start(8'd1);
        send_stream(32'hDEADBEEF, 0);
        wait_outcome();
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL async_reload_done: got %0b expected 1", done); end
        checks++; if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 7'd0 || wr_data_q[0] !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL async_reload_write: got %0d writes, first addr=%0d data=%08h, expected 1 write addr=0 data=deadbeef", wr_addr_q.size(), (wr_addr_q.size() > 0) ? wr_addr_q[0] : 7'd0, (wr_data_q.size() > 0) ? wr_data_q[0] : 32'h0); end
    endtask

    task automatic test_boundaries();
        bit expect_good;
        pulse_start(8'd0);
        checks++; if ({error, busy, byte_ready} !== 3'b100) begin failures++; $display("[TB] FAIL count0: got error/busy/ready=%03b expected 100", {error, busy, byte_ready}); end
        pulse_start(8'd129);
        checks++; if ({error, busy, byte_ready} !== 3'b100) begin failures++; $display("[TB] FAIL count129: got error/busy/ready=%03b expected 100", {error, busy, byte_ready}); end
        clear_log();
        prog_q.delete();
        for (int i = 0; i < 128; i++) prog_q.push_back(32'(i));
        expect_good = (model_xor() == 32'h0);
        pulse_start(8'd128);
        send_stream(32'h00000000, 0);
        wait_outcome();
        checks++; if (done !== expect_good || error !== !expect_good) begin failures++; $display("[TB] FAIL count128_outcome: got done=%0b error=%0b expected %0b %0b", done, error, expect_good, !expect_good); end
        checks++; if (wr_addr_q.size() != 128) begin failures++; $display("[TB] FAIL count128_strobes: got %0d writes expected 128", wr_addr_q.size()); end
        for (int i = 0; i < wr_addr_q.size() && i < prog_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== 7'(i) || wr_data_q[i] !== prog_q[i]) begin
                failures++;
                $display("[TB] FAIL count128_write%0d: got addr=%0d data=%08h expected addr=%0d data=%08h", i, wr_addr_q[i], wr_data_q[i], i, prog_q[i]);
            end
        end
    endtask

    task automatic test_reload();
        clear_log();
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL reload_pre: got done=%0b expected 1", done); end
        pulse_start(8'd1);
        checks++; if ({comp_rst, comp_en, done, busy} !== 4'b0101) begin failures++; $display("[TB] FAIL reload_entry: got comp_rst/comp_en/done/busy=%04b expected 0101", {comp_rst, comp_en, done, busy}); end
        pulse_start(8'd0);
        checks++; if (error !== 1'b0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL reload_start_ignored: got error=%0b busy=%0b expected 0 1", error, busy); end
        prog_q = '{32'h13579BDF};
        send_stream(32'h13579BDF, 0);
        wait_outcome();
        checks++; if (done !== 1'b1 || wr_addr_q.size() != 1) begin failures++; $display("[TB] FAIL reload_done: got done=%0b writes=%0d expected 1 1", done, wr_addr_q.size()); end
    endtask

    task automatic test_random_loads();
        int n;
        int gap;
        bit good;
        logic [31:0] csum;
        for (int it = 0; it < 8; it++) begin
            clear_log();
            prog_q.delete();
            n = int'($urandom_range(1, 8));
            for (int i = 0; i < n; i++) prog_q.push_back($urandom);
            good = 1'($urandom_range(0, 1));
            csum = good ? model_xor() : (model_xor() ^ (32'h1 << $urandom_range(0, 31)));
            gap  = int'($urandom_range(0, 2));
            pulse_start(8'(n));
            send_stream(csum, gap);
            wait_outcome();
            checks++; if (done !== good || error !== !good) begin failures++; $display("[TB] FAIL rand%0d_outcome: got done=%0b error=%0b expected %0b %0b", it, done, error, good, !good); end
            checks++; if (wr_addr_q.size() != n) begin failures++; $display("[TB] FAIL rand%0d_strobes: got %0d writes expected %0d", it, wr_addr_q.size(), n); end
            for (int i = 0; i < wr_addr_q.size() && i < prog_q.size(); i++) begin
                checks++;
                if (wr_addr_q[i] !== 7'(i) || wr_data_q[i] !== prog_q[i]) begin
                    failures++;
                    $display("[TB] FAIL rand%0d_write%0d: got addr=%0d data=%08h expected addr=%0d data=%08h", it, i, wr_addr_q[i], wr_data_q[i], i, prog_q[i]);
                end
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        word_count = 8'd0;
        byte_in    = 8'd0;
        byte_valid = 1'b0;
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_stalled_stream();
        test_async_reset();
        test_boundaries();
        test_reload();
        test_random_loads();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
